mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative multi-cycle multiply/divide unit that the EX stage issues to alongside the combinational ALU. It serves MIPS MULT/MULTU/DIV/DIVU and holds results in HI/LO registers for later MFHI/MFLO reads. It uses a start/busy/done handshake; the hazard logic stalls on busy.

Parameters:
N, 32, operand width; the iteration count equals N.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  issue request; sampled only when busy=0
op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV
inp1  input  N  multiplicand / dividend
inp2  input  N  multiplier / divisor
busy  output  1  operation in progress
done  output  1  one-cycle pulse; hi/lo were updated on the same edge
hi  output  N  MULT: upper product half; DIV: remainder
lo  output  N  MULT: lower product half; DIV: quotient

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation aborts with no done pulse.
- States: IDLE -> MUL or DIV -> FIX -> IDLE.
- IDLE:
  - If start=1 at edge E0: latch op, inp1, inp2.
  - For signed ops, convert operands to magnitudes and record result signs.
  - Load counter=N, busy=1, go to MUL (op[1]=0) or DIV (op[1]=1).
  - If start=0, remain in IDLE.
- MUL: shift-add, one multiplier bit per edge, LSB first, into a 2N-bit accumulator. Decrement counter; at 0 go to FIX.
- DIV: restoring division, one quotient bit per edge, MSB first. Decrement counter; at 0 go to FIX.
- FIX (one edge, E(N+1)):
  - Apply signs.
    - Product negated iff operand signs differ.
    - Quotient negated iff signs differ.
    - Remainder takes the dividend's sign.
  - Write hi/lo, set done=1, busy=0, go to IDLE.
- Latency: done is high in the cycle after edge E(N+1), i.e. N+1 edges after the start edge (33 for N=32). busy is high for exactly N+1 cycles. done clears after one cycle.
- Operands are captured at start; changes on inp1/inp2/op while busy have no effect.
- start while busy=1: ignored, not queued.
- start in the done cycle: accepted, since busy=0.
- hi/lo hold their value until the next FIX or reset.
- Divide by zero (DIV or DIVU): hi=inp1 (as latched), lo=all ones. No exception.
- DIV of 0x80000000 by -1: lo=0x80000000, hi=0 (wraps, no trap).
- All arithmetic is modulo 2^N per half; there are no overflow flags.

Optional Feature:
MDU_FLUSH_EN
- Defined: adds input port flush (1 bit), placed after op.
  - flush=1 at a clock edge while busy forces IDLE: busy=0, no done, hi/lo unchanged.
  - flush has priority over start in the same cycle.
  - flush in IDLE has no effect.
- Undefined: no flush port; an operation, once started, always completes.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after the start edge; busy high 33 cycles.
- MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU 6x7; pulse start again with DIVU 9/3 at edge 5 while busy; change inp1 mid-operation -> single done, hi=0, lo=42; second request ignored.
- Back-to-back: assert start during the done cycle (DIVU 9/3) -> accepted; second done 33 edges later with lo=3, hi=0.
- Complete MULTU 6x7 (lo=42), then start MULTU 2x2 and drive rst_n=0 at edge 10 -> busy=0, hi=lo=0 immediately (asynchronous), no done. With MDU_FLUSH_EN, flush at edge 10 instead -> busy=0, hi/lo keep 0/42, no done.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO result registers and a start/busy/done handshake.
// Optional MDU_FLUSH_EN adds a flush input that abandons an in-flight operation.
module mult_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
`ifdef MDU_FLUSH_EN
  input  logic         flush,
`endif
  input  logic [N-1:0] inp1,
  input  logic [N-1:0] inp2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  // state | meaning
  // S_IDLE | waiting for start; busy=0
  // S_MUL  | shift-add, one multiplier bit per edge (LSB first)
  // S_DIV  | restoring divide, one quotient bit per edge (MSB first)
  // S_FIX  | apply result signs, write hi/lo, pulse done
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam int CW = $clog2(N + 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_dec;
  logic [2*N-1:0] r_acc;
  logic [N-1:0]   r_opb;
  logic           r_neg_res;
  logic           r_neg_rem;
  logic           r_is_div;
  logic           r_done;
  logic [N-1:0]   r_hi;
  logic [N-1:0]   r_lo;
  logic           w_flush;

`ifdef MDU_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  logic           w_a_neg;
  logic           w_b_neg;
  logic [N-1:0]   w_mag_a;
  logic [N-1:0]   w_mag_b;
  logic [N:0]     w_mul_sum;
  logic [N:0]     w_rem_sh;
  logic [N:0]     w_diff;
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_quo;
  logic [N-1:0]   w_rmd;

  assign w_cnt_dec = r_cnt - CW'(1);
  assign w_a_neg   = op[0] & inp1[N-1];
  assign w_b_neg   = op[0] & inp2[N-1];
  assign w_mag_a   = w_a_neg ? -inp1 : inp1;
  assign w_mag_b   = w_b_neg ? -inp2 : inp2;

  assign w_mul_sum = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_opb} : {(N+1){1'b0}});

  // Upper half holds the partial remainder, lower half the dividend bits still to shift in.
  assign w_rem_sh  = r_acc[2*N-1:N-1];
  assign w_diff    = w_rem_sh - {1'b0, r_opb};

  assign w_prod    = r_neg_res ? -r_acc : r_acc;
  assign w_quo     = r_neg_res ? -r_acc[N-1:0] : r_acc[N-1:0];
  assign w_rmd     = r_neg_rem ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = op[1] ? S_DIV : S_MUL;
      S_MUL: begin
        if (w_flush)              w_state_nxt = S_IDLE;
        else if (w_cnt_dec == '0) w_state_nxt = S_FIX;
      end
      S_DIV: begin
        if (w_flush)              w_state_nxt = S_IDLE;
        else if (w_cnt_dec == '0) w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_is_div  <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt     <= CW'(N);
            r_is_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            if (op[1]) begin
              r_acc <= {{N{1'b0}}, w_mag_a};
              r_opb <= w_mag_b;
            end else begin
              r_acc <= {{N{1'b0}}, w_mag_b};
              r_opb <= w_mag_a;
            end
          end
        end
        S_MUL: begin
          r_cnt <= w_cnt_dec;
          r_acc <= {w_mul_sum, r_acc[N-1:1]};
        end
        S_DIV: begin
          r_cnt <= w_cnt_dec;
          if (!w_diff[N]) r_acc <= {w_diff[N-1:0],   r_acc[N-2:0], 1'b1};
          else            r_acc <= {w_rem_sh[N-1:0], r_acc[N-2:0], 1'b0};
        end
        S_FIX: begin
          if (!w_flush) begin
            r_done <= 1'b1;
            if (r_is_div) begin
              // Zero divisor leaves the dividend in the remainder; quotient is forced to all ones.
              r_hi <= w_rmd;
              r_lo <= (r_opb == '0) ? {N{1'b1}} : w_quo;
            end else begin
              r_hi <= w_prod[2*N-1:N];
              r_lo <= w_prod[N-1:0];
            end
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
